// File: rtl/case_conv_fifo.sv
// ASCII case converter feeding a DEPTH-entry FIFO with a registered valid/ready output stage.
// Bytes are converted on write, so each keeps the mode that was selected when it arrived.
module case_conv_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PTR_W:0]   o_count,
    output logic             o_overflow,
    input  logic             i_clr_ovf
);

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_LOWER  = 2'b11;

    // Output handshake: a byte moves to the transmitter on any rising edge where
    // o_valid and i_ready are both 1; o_data is held stable while o_valid=1 and i_ready=0.

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       conv_data;
    logic             is_lower;
    logic             is_upper;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic             load;

    always_comb begin
        is_lower  = (i_data >= 8'h61) && (i_data <= 8'h7A);
        is_upper  = (i_data >= 8'h41) && (i_data <= 8'h5A);
        conv_data = i_data;
        case (i_mode)
            MODE_PASS:   conv_data = i_data;
            MODE_TOGGLE: begin
                if (is_lower)      conv_data = i_data - 8'h20;
                else if (is_upper) conv_data = i_data + 8'h20;
            end
            MODE_UPPER:  if (is_lower) conv_data = i_data - 8'h20;
            MODE_LOWER:  if (is_upper) conv_data = i_data + 8'h20;
            default:     conv_data = i_data;
        endcase
    end

    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a byte.
    assign full  = (o_count == (PTR_W+1)'(DEPTH));
    assign wr_en = i_valid && !full;
    assign drop  = i_valid && full;
    assign load  = (o_count != '0) && (!o_valid || i_ready);

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= conv_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_valid    <= 1'b0;
            o_data     <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);

            if (load) begin
                o_data  <= mem[rd_ptr];
                o_valid <= 1'b1;
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case ({wr_en, load})
                2'b10:   o_count <= o_count + (PTR_W+1)'(1);
                2'b01:   o_count <= o_count - (PTR_W+1)'(1);
                default: o_count <= o_count;
            endcase

            if (drop)           o_overflow <= 1'b1;
            else if (i_clr_ovf) o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_case_conv_fifo.sv
// Bench for case_conv_fifo: vector table, hand-built corner sequences, and randomized
// traffic compared every cycle against a queue-based reference model.
module tb_case_conv_fifo;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic [7:0]       din;
    logic             vin;
    logic [1:0]       mode;
    logic [7:0]       dout;
    logic             vout;
    logic             rdy;
    logic [PTR_W:0]   cnt;
    logic             ovf;
    logic             clr;

    case_conv_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (din),
        .i_valid    (vin),
        .i_mode     (mode),
        .o_data     (dout),
        .o_valid    (vout),
        .i_ready    (rdy),
        .o_count    (cnt),
        .o_overflow (ovf),
        .i_clr_ovf  (clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovf;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] ref_conv(input logic [7:0] d, input logic [1:0] m);
        logic low_letter;
        logic up_letter;
        low_letter = (d >= "a") && (d <= "z");
        up_letter  = (d >= "A") && (d <= "Z");
        case (m)
            2'd1:    return low_letter ? d - 8'd32 : (up_letter ? d + 8'd32 : d);
            2'd2:    return low_letter ? d - 8'd32 : d;
            2'd3:    return up_letter  ? d + 8'd32 : d;
            default: return d;
        endcase
    endfunction

    task automatic model_edge();
        int  held;
        logic pop;
        if (!rst_n) begin
            m_q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            held = m_q.size();
            pop  = (held > 0) && (!m_valid || rdy);
            if (pop) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (vin && held < DEPTH) m_q.push_back(ref_conv(din, mode));
            if (vin && held == DEPTH) m_ovf = 1'b1;
            else if (clr)             m_ovf = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(vout), 32'(m_valid));
        check("model_data",  32'(dout), 32'(m_data));
        check("model_count", 32'(cnt),  32'(m_q.size()));
        check("model_ovf",   32'(ovf),  32'(m_ovf));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m,
                        input logic r, input logic c);
        vin  = v;
        din  = d;
        mode = m;
        rdy  = r;
        clr  = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle(input logic r);
        step(1'b0, 8'h00, 2'b00, r, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[16];
    logic [7:0] exp_q[$];

    initial begin
        int recv;
        int sent;
        logic v;
        logic r;
        logic [7:0] d;
        logic [1:0] m;

        vecs[0]  = '{2'b00, 8'h41, 8'h41};
        vecs[1]  = '{2'b00, 8'h7A, 8'h7A};
        vecs[2]  = '{2'b00, 8'h31, 8'h31};
        vecs[3]  = '{2'b00, 8'hE1, 8'hE1};
        vecs[4]  = '{2'b01, 8'h41, 8'h61};
        vecs[5]  = '{2'b01, 8'h7A, 8'h5A};
        vecs[6]  = '{2'b01, 8'h31, 8'h31};
        vecs[7]  = '{2'b01, 8'hE1, 8'hE1};
        vecs[8]  = '{2'b10, 8'h41, 8'h41};
        vecs[9]  = '{2'b10, 8'h7A, 8'h5A};
        vecs[10] = '{2'b10, 8'h31, 8'h31};
        vecs[11] = '{2'b10, 8'hE1, 8'hE1};
        vecs[12] = '{2'b11, 8'h41, 8'h61};
        vecs[13] = '{2'b11, 8'h7A, 8'h7A};
        vecs[14] = '{2'b11, 8'h31, 8'h31};
        vecs[15] = '{2'b11, 8'hE1, 8'hE1};

        rst_n = 1'b0;
        vin = 1'b0; din = 8'h00; mode = 2'b00; rdy = 1'b0; clr = 1'b0;
        idle(1'b0);
        idle(1'b0);
        check("reset_valid", 32'(vout), 32'd0);
        check("reset_data",  32'(dout), 32'h00);
        check("reset_count", 32'(cnt),  32'd0);
        check("reset_ovf",   32'(ovf),  32'd0);
        rst_n = 1'b1;

        // Test 1: two-edge latency, upper mode
        step(1'b1, 8'h61, 2'b10, 1'b1, 1'b0);
        check("t1_count_n",  32'(cnt),  32'd1);
        check("t1_valid_n",  32'(vout), 32'd0);
        idle(1'b1);
        check("t1_valid_n1", 32'(vout), 32'd1);
        check("t1_data_n1",  32'(dout), 32'h41);
        idle(1'b1);
        check("t1_valid_done", 32'(vout), 32'd0);
        check("t1_count_done", 32'(cnt),  32'd0);

        // Test 2: mode sweep from the table
        for (int i = 0; i < 16; i++) begin
            step(1'b1, vecs[i].din, vecs[i].mode, 1'b1, 1'b0);
            idle(1'b1);
            check($sformatf("t2_vec%0d_data", i), 32'(dout), 32'(vecs[i].dout));
            check($sformatf("t2_vec%0d_valid", i), 32'(vout), 32'd1);
            idle(1'b1);
        end

        // Test 3: fill past capacity with transmitter stalled
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 8'(i), 2'b00, 1'b0, 1'b0);
        check("t3_hold_data", 32'(dout), 32'h00);
        check("t3_count",     32'(cnt),  32'd16);
        check("t3_ovf",       32'(ovf),  32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(1'b1);
            check($sformatf("t3_drain%0d", i), 32'(dout), 32'(i));
            check($sformatf("t3_drain%0d_v", i), 32'(vout), 32'd1);
        end
        idle(1'b1);
        check("t3_empty", 32'(vout), 32'd0);

        // Test 4: drop on a pop cycle, then set-vs-clear priority
        step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        check("t4_clr", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'h20 + 8'(i), 2'b00, 1'b0, 1'b0);
        check("t4_full", 32'(cnt), 32'd16);
        step(1'b1, 8'h77, 2'b00, 1'b1, 1'b0);
        check("t4_pop_drop_ovf",   32'(ovf), 32'd1);
        check("t4_pop_drop_count", 32'(cnt), 32'd15);
        step(1'b1, 8'h78, 2'b00, 1'b0, 1'b0);
        step(1'b1, 8'h79, 2'b00, 1'b0, 1'b1);
        check("t4_set_wins", 32'(ovf), 32'd1);
        step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        check("t4_clear", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);

        // Test 5a: hold while stalled
        step(1'b1, 8'h5A, 2'b00, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            check("t5_hold", 32'(dout), 32'h5A);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Test 5b: 40-byte stream with random backpressure, scoreboarded in order
        sent = 0;
        recv = 0;
        for (int i = 0; i < 2000 && recv < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            v = (sent < 40) && (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            if (vout && r) begin
                if (exp_q.size() == 0) check("t5_unexpected", 32'(dout), 32'hFFFF_FFFF);
                else check("t5_stream_data", 32'(dout), 32'(exp_q.pop_front()));
                recv++;
            end
            if (v) begin
                exp_q.push_back(ref_conv(d, m));
                sent++;
            end
            step(v, d, m, r, 1'b0);
        end
        check("t5_stream_count", 32'(recv), 32'd40);

        // Test 6: reset mid-transfer discards everything
        for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 2'b00, 1'b0, 1'b0);
        check("t6_pre_count", 32'(cnt),  32'd5);
        check("t6_pre_valid", 32'(vout), 32'd1);
        rst_n = 1'b0;
        step(1'b1, 8'h61, 2'b10, 1'b1, 1'b0);
        check("t6_rst_valid", 32'(vout), 32'd0);
        check("t6_rst_data",  32'(dout), 32'h00);
        check("t6_rst_count", 32'(cnt),  32'd0);
        check("t6_rst_ovf",   32'(ovf),  32'd0);
        rst_n = 1'b1;
        step(1'b1, 8'h62, 2'b10, 1'b1, 1'b0);
        idle(1'b1);
        check("t6_after_data",  32'(dout), 32'h42);
        check("t6_after_valid", 32'(vout), 32'd1);
        idle(1'b1);

        // Random soak: overflow, clears and backpressure all mixed
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/case_conv_fifo.md
Name: case_conv_fifo

Overview:
Stage directly downstream of the UART receiver in the case-converter datapath. Accepts each received byte as a single-cycle valid pulse and applies the selected ASCII case transform. Buffers results in a DEPTH-entry FIFO and presents them to the UART transmitter through a valid/ready handshake. Absorbs the rate mismatch between back-to-back receptions and a busy transmitter, and flags dropped bytes.

Parameters:
DEPTH, 16, FIFO memory entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  synchronous reset, active-low
i_data  input  8  received byte, valid only while i_valid=1
i_valid  input  1  single-cycle pulse: i_data holds a new byte
i_mode  input  2  case mode, sampled with i_valid: 00 pass, 01 toggle, 10 upper, 11 lower
o_data  output  8  converted byte to transmitter
o_valid  output  1  o_data holds a byte awaiting transfer
i_ready  input  1  transmitter can accept; transfer when o_valid & i_ready at rising edge
o_count  output  PTR_W+1  bytes held in FIFO memory (0..DEPTH), excluding output register
o_overflow  output  1  sticky: a byte was dropped because memory was full
i_clr_ovf  input  1  clears o_overflow

Behaviour:
- Reset (i_rst_n=0 at rising edge): wr/rd pointers=0, o_count=0, o_valid=0, o_data=8'h00, o_overflow=0. Memory contents not reset. Reset overrides every other input in that cycle, including mid-transfer; all held bytes are discarded.
- Conversion (combinational on i_data, selected by i_mode):
  - upper: 0x61-0x7A -> minus 0x20
  - lower: 0x41-0x5A -> plus 0x20
  - toggle: both rules
  - pass: unchanged
  - All other bytes, including 0x80-0xFF and punctuation, unchanged in every mode.
- Write: at an edge with i_valid=1 and o_count<DEPTH, the converted byte is written at wr_ptr, and wr_ptr increments (wraps modulo DEPTH).
- Full drop: at an edge with i_valid=1 and o_count==DEPTH, the byte is discarded and o_overflow is set. Fullness is evaluated on the pre-edge count, so the byte is dropped even if a memory pop occurs in the same cycle.
- Output register load: load = (o_count>0) & (!o_valid | i_ready).
  - On load: o_data <= mem[rd_ptr], o_valid <= 1, rd_ptr increments (wraps).
  - Else, if o_valid & i_ready: o_valid <= 0.
  - Else: hold. o_data stays stable while o_valid=1 and i_ready=0.
- Count update: o_count next = o_count + write - load. A simultaneous write and load leaves the count unchanged.
- No bypass. Timing with an empty FIFO:
  - i_valid sampled at edge N: o_count=1 after N.
  - o_valid=1 after edge N+1.
  - Fixed latency: 2 edges from i_valid to o_valid.
- Throughput: with i_ready held 1, one byte per cycle leaves the output register (back-to-back loads).
- Overflow flag:
  - set on a drop
  - cleared by i_clr_ovf=1
  - a set and a clear in the same cycle: set wins
  - unaffected by reads
- i_mode is sampled only when i_valid=1. Bytes already buffered keep the case applied at write.
- Total capacity is DEPTH+1 bytes (memory plus output register).

Test Plan:
1. Reset, mode=10, i_valid pulse with 0x61 ('a'), i_ready=1 -> o_valid=1 with o_data=0x41 exactly 2 edges after the pulse, o_valid=0 the cycle after transfer; o_count returns to 0.
2. Mode sweep on bytes 0x41,0x7A,0x31,0xE1:
   - pass -> unchanged
   - toggle -> 0x61,0x5A,0x31,0xE1
   - upper -> 0x41,0x5A,0x31,0xE1
   - lower -> 0x61,0x7A,0x31,0xE1
3. i_ready=0, write DEPTH+2 bytes 0x00..0x11 (DEPTH=16) -> output reg holds 0x00, o_count=16, byte 0x11 dropped, o_overflow=1. Then i_ready=1 -> 0x00..0x10 emitted in order with no gaps.
4. Memory full, i_ready=1, and i_valid in the same cycle as a pop -> incoming byte dropped, o_overflow=1, o_count=15. Then i_clr_ovf together with another drop -> o_overflow stays 1; i_clr_ovf alone -> o_overflow=0.
5. Hold and wrap:
   - o_valid=1, i_ready=0 for 10 cycles -> o_data unchanged.
   - Stream 40 bytes through with random i_ready, DEPTH=16 -> all 40 received in order, pointers wrap correctly.
6. Assert i_rst_n=0 with o_count=5 and o_valid=1 -> next edge: o_valid=0, o_data=0x00, o_count=0, o_overflow=0; a subsequent byte emits normally.
